// File: rtl/char_stream_pkg.sv
// Shared types and constants for the character-stream arbiter and the block checker.
package char_stream_pkg;

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Round-robin successor of a source index, wrapping at n.
  function automatic int unsigned next_src(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/char_stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder; returns the first set request at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand_s;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand_s = W'((int'(ptr) + off) % N);
      idx    = req[cand_s] ? cand_s : idx;
      any    = any | req[cand_s];
    end
  end

endmodule

// File: rtl/char_stream_arbiter.sv
// char_stream_arbiter: per-message round-robin sharing of one character datapath.
// Define CHAR_ARB_TIMEOUT_EN to enable the stall watchdog, ABORT state and out_abort pulse.
module char_stream_arbiter
  import char_stream_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          req_valid,
  input  logic [CHAR_W*N_SRC-1:0]   req_data,
  input  logic [N_SRC-1:0]          req_last,
  output logic [N_SRC-1:0]          req_ready,
  output logic                      out_valid,
  output logic [CHAR_W-1:0]         out_data,
  output logic [$clog2(N_SRC)-1:0]  out_src,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      out_abort
);

  localparam int SRC_W = $clog2(N_SRC);

  if (N_SRC < 32'sd2 || N_SRC > 32'sd8 || TIMEOUT < 32'sd2) begin : g_param_check
    $error("char_stream_arbiter: parameter out of range");
  end

  arb_state_e        state_r, state_s;
  logic [SRC_W-1:0]  grant_r, grant_s;
  logic [SRC_W-1:0]  ptr_r, ptr_s;
  logic [SRC_W-1:0]  pick_idx_s, next_ptr_s;
  logic              pick_any_s;
  logic              src_valid_s, src_last_s, xfer_s;
  logic [CHAR_W-1:0] src_data_s;
  logic [CHAR_W-1:0] data_arr_s [N_SRC];

`ifdef CHAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_s;
`endif

  rr_pick #(.N(N_SRC), .W(SRC_W)) u_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign next_ptr_s = SRC_W'(next_src(32'(grant_r), 32'(N_SRC)));

  // Unpack the flat data bus and select the granted source's lane.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      data_arr_s[i] = req_data[i*CHAR_W +: CHAR_W];
    end
    src_valid_s = req_valid[grant_r];
    src_last_s  = req_last[grant_r];
    src_data_s  = data_arr_s[grant_r];
  end

  // Next-state, grant/pointer update and combinational passthrough outputs.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    ptr_s     = ptr_r;
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = '0;
    out_last  = 1'b0;
    out_abort = 1'b0;
    xfer_s    = 1'b0;
`ifdef CHAR_ARB_TIMEOUT_EN
    stall_cnt_s = stall_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_s = pick_idx_s;
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        out_valid          = src_valid_s;
        out_data           = src_valid_s ? src_data_s : '0;
        out_last           = src_valid_s & src_last_s;
        out_src            = grant_r;
        req_ready[grant_r] = out_ready;
        xfer_s             = src_valid_s & out_ready;
        if (xfer_s && src_last_s) begin
          state_s = ST_IDLE;
          ptr_s   = next_ptr_s;
        end else begin
          state_s = ST_BUSY;
        end
`ifdef CHAR_ARB_TIMEOUT_EN
        // Backpressure with a valid source is not a stall: only source silence counts.
        if (src_valid_s) begin
          stall_cnt_s = '0;
        end else if (stall_cnt_r + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          stall_cnt_s = '0;
          state_s     = ST_ABORT;
        end else begin
          stall_cnt_s = stall_cnt_r + CNT_W'(1);
        end
`endif
      end
      ST_ABORT: begin
`ifdef CHAR_ARB_TIMEOUT_EN
        out_abort = 1'b1;
`endif
        state_s = ST_IDLE;
        ptr_s   = next_ptr_s;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      ptr_r   <= ptr_s;
    end
  end

`ifdef CHAR_ARB_TIMEOUT_EN
  // Stall watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_char_stream_arbiter.sv
// Self-checking bench for char_stream_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_char_stream_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        out_ready;
  logic        out_abort;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  char_stream_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_abort (out_abort)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic clear_all();
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_last  = 4'b0000;
  endtask

  // Spec rule: first valid source scanning p, p+1, ... wrapping.
  function automatic int rr_expect(input logic [3:0] vmask, input int p);
    for (int k = 0; k < N; k++) begin
      if (vmask[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hA5A5_A5A5;
    req_last  = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_src, out_last, out_abort, req_ready} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_data, out_src, out_last, out_abort, req_ready});
    end
    clear_all();
    tick();
  endtask

  task automatic test_single_source();
    string msg = "begin end";
    logic [7:0] ch;
    reset = 1'b0;
    out_ready = 1'b1;
    ch = msg[0];
    set_src(1, 1'b1, ch, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL single_arb_cycle: got %b expected 00000", {out_valid, req_ready});
    end
    tick();
    for (int j = 0; j < 9; j++) begin
      ch = msg[j];
      set_src(1, 1'b1, ch, (j == 8));
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data, out_last, req_ready} !== {1'b1, 2'd1, ch, (j == 8), 4'b0010}) begin
        errors++;
        $display("FAIL single_xfer_%0d: got %h expected %h", j,
                 {out_valid, out_src, out_data, out_last, req_ready}, {1'b1, 2'd1, ch, (j == 8), 4'b0010});
      end
      tick();
    end
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h30, 1'b1);
    set_src(3, 1'b1, 8'h33, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL single_gap: got %b expected 00000", {out_valid, req_ready});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd3, 8'h33}) begin
      errors++;
      $display("FAIL single_ptr_is_2: got %h expected %h", {out_valid, out_src, out_data}, {1'b1, 2'd3, 8'h33});
    end
    tick();
    set_src(3, 1'b0, 8'h00, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 8'h30}) begin
      errors++;
      $display("FAIL single_waiter_served: got %h expected %h", {out_valid, out_src, out_data}, {1'b1, 2'd0, 8'h30});
    end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_two_sources();
    string s0 = "abc";
    string s2 = "xyz";
    logic [7:0] ch;
    reset = 1'b1;
    clear_all();
    tick();
    reset = 1'b0;
    ch = s0[0];
    set_src(0, 1'b1, ch, 1'b0);
    ch = s2[0];
    set_src(2, 1'b1, ch, 1'b0);
    tick();
    for (int j = 0; j < 3; j++) begin
      ch = s0[j];
      set_src(0, 1'b1, ch, (j == 2));
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data, out_last, req_ready} !== {1'b1, 2'd0, ch, (j == 2), 4'b0001}) begin
        errors++;
        $display("FAIL two_src0_%0d: got %h expected %h", j,
                 {out_valid, out_src, out_data, out_last, req_ready}, {1'b1, 2'd0, ch, (j == 2), 4'b0001});
      end
      tick();
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL two_gap: got %b expected 00000", {out_valid, req_ready});
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      ch = s2[j];
      set_src(2, 1'b1, ch, (j == 2));
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data, out_last, req_ready} !== {1'b1, 2'd2, ch, (j == 2), 4'b0100}) begin
        errors++;
        $display("FAIL two_src2_%0d: got %h expected %h", j,
                 {out_valid, out_src, out_data, out_last, req_ready}, {1'b1, 2'd2, ch, (j == 2), 4'b0100});
      end
      tick();
    end
    set_src(2, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h40, 1'b1);
    set_src(3, 1'b1, 8'h43, 1'b1);
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_src} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL two_ptr_is_3: got %h expected %h", {out_valid, out_src}, {1'b1, 2'd3});
    end
    tick();
    set_src(3, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_src(3, 1'b1, 8'h71, 1'b0);
    tick();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_src, out_data, req_ready, out_abort} !== {1'b1, 2'd3, 8'h71, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got %h expected %h", c,
                 {out_valid, out_src, out_data, req_ready, out_abort}, {1'b1, 2'd3, 8'h71, 4'b0000, 1'b0});
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL backpressure_resume: got %b expected 1000", req_ready);
    end
    tick();
    set_src(3, 1'b1, 8'h72, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, out_src, out_data, out_last} !== {1'b1, 2'd3, 8'h72, 1'b1}) begin
      errors++;
      $display("FAIL backpressure_last: got %h expected %h", {out_valid, out_src, out_data, out_last}, {1'b1, 2'd3, 8'h72, 1'b1});
    end
    tick();
    clear_all();
    tick();
  endtask

`ifdef CHAR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    string s = "beg";
    logic [7:0] ch;
    out_ready = 1'b1;
    ch = s[0];
    set_src(0, 1'b1, ch, 1'b0);
    tick();
    for (int j = 0; j < 3; j++) begin
      ch = s[j];
      set_src(0, 1'b1, ch, 1'b0);
      tick();
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      checks++;
      if ({out_abort, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL timeout_early_%0d: got %b expected 00", k, {out_abort, out_valid});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid, req_ready} !== 6'b100000) begin
      errors++;
      $display("FAIL timeout_abort_pulse: got %b expected 100000", {out_abort, out_valid, req_ready});
    end
    tick();
    set_src(0, 1'b1, 8'h50, 1'b1);
    set_src(1, 1'b1, 8'h51, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_then_idle: got %b expected 00", {out_abort, out_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_src} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL timeout_ptr_is_1: got %h expected %h", {out_valid, out_src}, {1'b1, 2'd1});
    end
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    clear_all();
    tick();
    set_src(0, 1'b1, 8'h62, 1'b0);
    tick();
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      checks++;
      if (out_abort !== 1'b0) begin
        errors++;
        $display("FAIL timeout_boundary_idle_%0d: got %b expected 0", k, out_abort);
      end
      tick();
    end
    set_src(0, 1'b1, 8'h65, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid, out_src, out_data, out_last} !== {1'b0, 1'b1, 2'd0, 8'h65, 1'b1}) begin
      errors++;
      $display("FAIL timeout_boundary_valid: got %h expected %h",
               {out_abort, out_valid, out_src, out_data, out_last}, {1'b0, 1'b1, 2'd0, 8'h65, 1'b1});
    end
    tick();
    clear_all();
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_boundary_after: got %b expected 00", {out_abort, out_valid});
    end
    tick();
  endtask
`else
  task automatic test_long_stall();
    out_ready = 1'b1;
    set_src(0, 1'b1, 8'h62, 1'b0);
    tick();
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({out_abort, out_valid, out_src, req_ready} !== {1'b0, 1'b0, 2'd0, 4'b0001}) begin
        errors++;
        $display("FAIL long_stall_hold_%0d: got %h expected %h", k,
                 {out_abort, out_valid, out_src, req_ready}, {1'b0, 1'b0, 2'd0, 4'b0001});
      end
      tick();
    end
    set_src(0, 1'b1, 8'h65, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, out_src, out_data, out_last} !== {1'b1, 2'd0, 8'h65, 1'b1}) begin
      errors++;
      $display("FAIL long_stall_complete: got %h expected %h", {out_valid, out_src, out_data, out_last}, {1'b1, 2'd0, 8'h65, 1'b1});
    end
    tick();
    clear_all();
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL long_stall_idle: got %b expected 00", {out_abort, out_valid});
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b1;
    set_src(2, 1'b1, 8'h62, 1'b0);
    tick();
    tick();
    set_src(2, 1'b1, 8'h65, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_src, out_last, out_abort, req_ready} !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {out_valid, out_data, out_src, out_last, out_abort, req_ready});
    end
    tick();
    reset = 1'b0;
    set_src(2, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h70, 1'b1);
    set_src(3, 1'b1, 8'h73, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_abort, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_no_abort: got %b expected 00", {out_abort, out_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 8'h70}) begin
      errors++;
      $display("FAIL reset_mid_ptr_is_0: got %h expected %h", {out_valid, out_src, out_data}, {1'b1, 2'd0, 8'h70});
    end
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_random();
    logic [8:0] mem [4][16];
    int head [4];
    int tail [4];
    int low [4];
    bit started [4];
    logic [3:0] vld;
    logic [7:0] exp_d;
    logic exp_l;
    int phase, owner, next_owner, mptr, cyc, nm, len;
    bit xfer, any_pend;
    reset = 1'b1;
    clear_all();
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      low[i] = 0;
      started[i] = 1'b0;
      nm = $urandom_range(1, 3);
      for (int m = 0; m < nm; m++) begin
        len = $urandom_range(1, 4);
        for (int c = 0; c < len; c++) begin
          mem[i][tail[i]] = {(c == len - 1), 8'($urandom)};
          tail[i]++;
        end
      end
    end
    phase = 0;
    owner = 0;
    mptr = 0;
    cyc = 0;
    while (cyc < 3000) begin
      any_pend = 1'b0;
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) any_pend = 1'b1;
      if (!any_pend && phase == 0) break;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (head[i] >= tail[i]) begin
          vld[i] = 1'b0;
          low[i] = 0;
          set_src(i, 1'b0, 8'h00, 1'b0);
        end else begin
          vld[i] = !started[i] || low[i] >= 2 || ($urandom_range(0, 2) != 0);
          low[i] = vld[i] ? 0 : low[i] + 1;
          set_src(i, vld[i], mem[i][head[i]][7:0], mem[i][head[i]][8]);
        end
      end
      @(negedge clk);
      xfer = 1'b0;
      next_owner = -1;
      checks++;
      if (out_abort !== 1'b0) begin
        errors++;
        $display("FAIL random_abort_c%0d: got %b expected 0", cyc, out_abort);
      end
      if (phase == 0) begin
        checks++;
        if ({out_valid, out_data, req_ready} !== 13'h0) begin
          errors++;
          $display("FAIL random_idle_c%0d: got %h expected 0", cyc, {out_valid, out_data, req_ready});
        end
        next_owner = rr_expect(vld, mptr);
      end else begin
        exp_d = vld[owner] ? mem[owner][head[owner]][7:0] : 8'h00;
        exp_l = vld[owner] ? mem[owner][head[owner]][8] : 1'b0;
        checks++;
        if ({out_valid, out_src, out_data, out_last, req_ready} !==
            {vld[owner], 2'(owner), exp_d, exp_l, (out_ready ? 4'(32'd1 << owner) : 4'b0000)}) begin
          errors++;
          $display("FAIL random_busy_c%0d: got %h expected %h", cyc, {out_valid, out_src, out_data, out_last, req_ready},
                   {vld[owner], 2'(owner), exp_d, exp_l, (out_ready ? 4'(32'd1 << owner) : 4'b0000)});
        end
        xfer = vld[owner] && out_ready;
      end
      tick();
      if (phase == 1 && xfer) begin
        exp_l = mem[owner][head[owner]][8];
        head[owner]++;
        started[owner] = !exp_l;
        if (exp_l) begin
          phase = 0;
          mptr = (owner + 1) % N;
        end
      end else if (phase == 0 && next_owner >= 0) begin
        phase = 1;
        owner = next_owner;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL random_drain: got %0d cycles expected under 3000", cyc);
    end
    clear_all();
    tick();
  endtask

  initial begin
    clear_all();
    reset = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_single_source();
    test_two_sources();
    test_backpressure();
`ifdef CHAR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/char_stream_arbiter.md
# char_stream_arbiter

Shares one downstream `begin`/`end` block-checking datapath between `N_SRC` independent 8-bit character sources. Grants the datapath to one source per message: round-robin selection, grant held until that source's `last` character transfers. Without this, the checker's per-stream nesting state would be corrupted by interleaved text. An optional stall watchdog aborts a message whose source goes silent and tells the checker to discard it. Sits between the character sources and the block checker's `in` port.

## Interface
- `N_SRC`, 4: number of character sources, 2..8
- `TIMEOUT`, 16: consecutive source-idle cycles before abort, ≥2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  N_SRC  source i presents a character
- `req_data`  in  8*N_SRC  source i character at bits [8i+7:8i]
- `req_last`  in  N_SRC  character is the final one of the message
- `req_ready`  out  N_SRC  source i character accepted this cycle when valid&ready
- `out_valid`  out  1  character presented to checker
- `out_data`  out  8  character; 0 when `out_valid`=0
- `out_src`  out  clog2(N_SRC)  index of granted source
- `out_last`  out  1  final character of message
- `out_ready`  in  1  checker accepts character
- `out_abort`  out  1  one-cycle pulse: current message discarded, checker must reset its stream state

## Operation
- States: IDLE, BUSY, ABORT. Regs: `state`, `grant`, `ptr`, `stall_cnt` (width clog2(TIMEOUT+1)).
- IDLE: all `req_ready`=0, `out_valid`=0. If any `req_valid`, pick first set bit scanning ptr, ptr+1, …, N_SRC-1, 0, …, ptr-1. Register it into `grant`, go BUSY. No character transfers in IDLE.
- BUSY: combinational passthrough from `grant`:
  - `out_valid`=`req_valid[grant]`, `out_data`/`out_last` from source `grant`.
  - `req_ready[grant]`=`out_ready`; all others 0.
  - `out_src`=`grant`.
  - Transfer = `out_valid & out_ready`.
  - Transfer with `last` → IDLE, `ptr`=(grant+1) mod N_SRC.
- Stall watchdog (BUSY only): `stall_cnt` clears on any cycle with `req_valid[grant]`=1. Otherwise it increments.
  - When the increment would reach TIMEOUT → ABORT.
  - `out_ready`=0 with source valid is backpressure, not stall; the counter clears.
- ABORT: `out_abort`=1 for exactly one cycle, `out_valid`=0, all `req_ready`=0. Then IDLE, `ptr`=(grant+1) mod N_SRC, `stall_cnt`=0.
- Non-granted sources are never dropped; they wait with valid held.
- Reset mid-message: message silently dropped, no `out_abort`.

## Timing
- Reset values: state IDLE, `grant`=0, `ptr`=0, `stall_cnt`=0. Outputs: `out_valid`=0, `out_data`=0, `out_src`=0, `out_last`=0, `out_abort`=0, `req_ready`=0.
- Arbitration latency: request seen in IDLE at edge k, so the first character can transfer in cycle k+1.
- Passthrough latency: 0 cycles, combinational, in BUSY.
- Gap between messages: exactly one IDLE cycle after a `last` transfer, even when other requests are pending.
- Abort timing: the source is idle in TIMEOUT consecutive BUSY cycles. `out_abort` is high in the next cycle. IDLE follows in the cycle after that.
- Source valid in the cycle that would hit TIMEOUT: the counter clears and no abort occurs, whether or not the character transfers.
- `ptr` wraps N_SRC-1 → 0.

## Configuration
- `CHAR_ARB_TIMEOUT_EN` defined: `stall_cnt`, the ABORT state and `out_abort` behave as above.
- `CHAR_ARB_TIMEOUT_EN` undefined: no counter and no ABORT state. `out_abort` is tied 0. The grant is held indefinitely until `last` transfers.

## Structure
- Shared package `char_stream_pkg`:
  - state encoding constants `ST_IDLE`, `ST_BUSY`, `ST_ABORT`
  - `CHAR_SPACE`=8'h20
  - `CHAR_W`=8
  - the same package is used by the block checker.
- Sub-module `rr_pick`: combinational round-robin first-set-bit finder. Inputs `req[N_SRC]` and `ptr`. Outputs `idx` and `any`.

## Test plan
- Source 1 only sends "begin end" (9 chars, `last` on 'd'), `out_ready`=1:
  - grant taken in cycle 1
  - 9 transfers with `out_src`=1
  - IDLE afterward, `ptr`=2.
- Sources 0 and 2 both request at reset release, 3-char messages each:
  - source 0 is served fully first
  - one IDLE cycle
  - then source 2
  - `ptr` ends at 3.
- Source 3 granted; `out_ready` is low for 40 cycles while `req_valid` is held:
  - no abort
  - `req_ready[3]`=0 throughout
  - transfer resumes when ready rises.
- Source 0 sends "beg", then drops valid for 16 cycles (TIMEOUT=16):
  - `out_abort` pulses once, in cycle 17 after the last valid
  - then IDLE with `ptr`=1.
  - Repeat with valid returning on idle cycle 16: no abort.
- Reset asserted mid-message:
  - all outputs at reset values on the next cycle
  - no `out_abort`
  - `ptr`=0.
- With `CHAR_ARB_TIMEOUT_EN` undefined, a 100-cycle stall:
  - grant is held
  - `out_abort` stays 0
  - the message completes normally.
